// File: rtl/alu_bit_serial_seq.sv
// Bit-serial WIDTH-bit ALU: one alu_1bit stepped LSB-first, carry chained through a register.
// Latency: out_valid rises WIDTH cycles after the accepting edge; one op per WIDTH+2 cycles at best.
// Backpressure: in_ready only in IDLE; result/cout held in DONE until out_ready, indefinitely.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake carrying a, b, op, cin
//   a, b [WIDTH]           operands
//   op [2]                 00 AND, 01 OR, 10 XOR, 11 ADD
//   cin                    carry-in, used only for ADD
//   out_valid/out_ready    result handshake carrying result, cout
//   result [WIDTH], cout   result word; carry out of MSB for ADD, 0 otherwise

module alu_1bit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       r,
    output logic       cout
);
    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        unique case (op)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: r = a ^ b;
            2'b11: begin
                r    = a ^ b ^ cin;
                cout = (a & b) | (cin & (a ^ b));
            end
            default: r = 1'b0;
        endcase
    end
endmodule

module alu_bit_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int         IDX_W  = $clog2(WIDTH);
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh, b_sh, res_q;
    logic [1:0]         op_q;
    logic               carry_q;
    logic [IDX_W-1:0]   bit_idx;
    logic               last_bit;
    logic               alu_r, alu_co;

    assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));

    alu_1bit u_alu (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .op   (op_q),
        .r    (alu_r),
        .cout (alu_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. carry_q is only ever loaded with a non-zero value for ADD,
    // so it doubles as the cout register for logic ops (always 0 there).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            op_q    <= 2'b00;
            carry_q <= 1'b0;
            bit_idx <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        op_q    <= op;
                        carry_q <= (op == OP_ADD) ? cin : 1'b0;
                        bit_idx <= '0;
                    end
                end
                RUN: begin
                    res_q[bit_idx] <= alu_r;
                    a_sh           <= a_sh >> 1;
                    b_sh           <= b_sh >> 1;
                    carry_q        <= (op_q == OP_ADD) ? alu_co : 1'b0;
                    if (!last_bit) bit_idx <= bit_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign cout   = carry_q;
endmodule

// File: tb/tb_alu_bit_serial_seq.sv
module tb_alu_bit_serial_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         cin;
    logic         out_valid, out_ready;
    logic [W-1:0] result;
    logic         cout;

    alu_bit_serial_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;
    logic [W:0] exp_q[$];   // {cout, result}
    int         acc_q[$];   // accept cycle per op, for latency checks
    logic       prev_ov = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compares whenever a result handshake is about to happen.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(W));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("result_cout", {55'd0, cout, result}, {55'd0, exp_q.pop_front()});
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [1:0] top, input logic tcin,
                        input logic [W-1:0] er, input logic ec, input bit check_gap);
        int n = 0;
        @(negedge clk);
        a = ta; b = tb_; op = top; cin = tcin; in_valid = 1'b1;
        while (!in_ready) begin
            if (n++ > 100) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_q.push_back({ec, er});
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        if (check_gap) chk("accept_gap", 64'(cyc - last_acc), 64'(W + 2));
        last_acc = cyc;
        // Scramble inputs after acceptance; the op in flight must not notice.
        in_valid = 1'b0;
        a = ~ta; b = 8'h5A; op = ~top; cin = ~tcin;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && exp_q.size() == 0)) begin
            if (n++ > 100) begin
                chk("idle_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid) begin
            if (n++ > 100) begin
                chk("out_valid_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] a, b;
        logic [1:0]   op;
        logic         cin;
        logic [W-1:0] r;
        logic         c;
    } vec_t;

    vec_t basic[5] = '{
        '{8'hFF, 8'h01, 2'b11, 1'b0, 8'h00, 1'b1},
        '{8'h7F, 8'h00, 2'b11, 1'b1, 8'h80, 1'b0},
        '{8'hA5, 8'hFF, 2'b10, 1'b1, 8'h5A, 1'b0},
        '{8'hF0, 8'h3C, 2'b00, 1'b1, 8'h30, 1'b0},
        '{8'hF0, 8'h0C, 2'b01, 1'b0, 8'hFC, 1'b0}
    };

    vec_t b2b[6] = '{
        '{8'h3C, 8'h0F, 2'b11, 1'b0, 8'h4B, 1'b0},
        '{8'h80, 8'h80, 2'b11, 1'b1, 8'h01, 1'b1},
        '{8'h0F, 8'hF0, 2'b10, 1'b0, 8'hFF, 1'b0},
        '{8'h00, 8'h00, 2'b01, 1'b1, 8'h00, 1'b0},
        '{8'hFF, 8'hAA, 2'b00, 1'b0, 8'hAA, 1'b0},
        '{8'hFF, 8'hFF, 2'b11, 1'b1, 8'hFF, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = 2'b00; cin = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ops, one at a time.
        foreach (basic[i]) begin
            send(basic[i].a, basic[i].b, basic[i].op, basic[i].cin, basic[i].r, basic[i].c, 1'b0);
            wait_idle();
        end

        // Stall in DONE for 3 cycles with in_valid pulsed during RUN and DONE.
        out_ready = 1'b0;
        send(8'hF0, 8'h3C, 2'b00, 1'b0, 8'h30, 1'b0, 1'b0);
        in_valid = 1'b1; a = 8'h00; b = 8'h00; op = 2'b11;
        @(negedge clk);
        chk("run_in_ready", in_ready, 0);
        wait_out_valid();
        for (int k = 0; k < 3; k++) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result", result, 8'h30);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_stall_out_valid", out_valid, 0);
        chk("post_stall_in_ready", in_ready, 1);
        out_ready = 1'b0;
        @(negedge clk);
        chk("out_ready_low_idle", in_ready, 1);
        out_ready = 1'b1;

        // Abort an ADD at bit 4 with reset.
        send(8'h0F, 8'h01, 2'b11, 1'b0, 8'h10, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h01, 8'h01, 2'b11, 1'b0, 8'h02, 1'b0, 1'b0);
        wait_idle();

        // Back-to-back with out_ready held high.
        foreach (b2b[i])
            send(b2b[i].a, b2b[i].b, b2b[i].op, b2b[i].cin, b2b[i].r, b2b[i].c, i != 0);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
